// File: rtl/xs3_bcd_serial_codec_if.sv
// xs3_bcd_serial_codec_if
// Bundles the producer and consumer handshakes of the Excess-3 / BCD codec.
//   mode, in_valid, in_data   : producer -> codec (word to convert and its direction)
//   in_ready                  : codec -> producer (a word can be accepted)
//   out_valid, out_data,
//   out_err_mask, err_cnt     : codec -> consumer (converted word, invalid-digit flags, error total)
//   out_ready                 : consumer -> codec (result taken)
// The master modport is the environment side; the slave modport is the codec.
interface xs3_bcd_serial_codec_if #(
  parameter int DIGITS = 4,
  parameter int ERR_W  = 8
);
  logic                  mode;
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_data;
  logic [DIGITS-1:0]     out_err_mask;
  logic [ERR_W-1:0]      err_cnt;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err_mask, err_cnt
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err_mask, err_cnt
  );
endinterface

// File: rtl/xs3_bcd_serial_codec.sv
// xs3_bcd_serial_codec
// Converts a packed multi-digit word between Excess-3 and BCD, one digit per
// clock, least-significant digit first. Invalid digits come out as 4'hF, are
// flagged in the error mask and counted in a saturating error counter.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : xs3_bcd_serial_codec_if.slave (input/output handshakes, data, flags)
module xs3_bcd_serial_codec #(
  parameter int DIGITS = 4,
  parameter int ERR_W  = 8
) (
  input logic                    clk,
  input logic                    rst,
  xs3_bcd_serial_codec_if.slave  bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t               state_q, state_d;
  logic [4*DIGITS-1:0]  src_q;
  logic [4*DIGITS-1:0]  res_q;
  logic [DIGITS-1:0]    mask_q;
  logic                 mode_q;
  logic [IDX_W-1:0]     idx_q;
  logic [ERR_W-1:0]     err_q;

  logic [3:0]           cur_digit;
  logic [3:0]           conv_digit;
  logic                 cur_bad;

  // Per-digit converter for the digit currently selected by the index.
  // Defaults describe the invalid case so only valid codes need a branch.
  always_comb begin
    cur_digit  = src_q[4*int'(idx_q) +: 4];
    conv_digit = 4'hF;
    cur_bad    = 1'b1;
    if (!mode_q) begin
      if (cur_digit >= 4'h3 && cur_digit <= 4'hC) begin
        conv_digit = cur_digit - 4'h3;
        cur_bad    = 1'b0;
      end
    end else begin
      if (cur_digit <= 4'h9) begin
        conv_digit = cur_digit + 4'h3;
        cur_bad    = 1'b0;
      end
    end
  end

  // Next-state and handshake outputs. Input is only taken in IDLE, so an
  // output handshake in DONE can never coincide with an input accept.
  always_comb begin
    state_d      = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = CONV;
      end
      CONV: begin
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register plus the datapath: latch the word on accept, write one
  // result nibble and mask bit per CONV cycle, and bump the saturating
  // error counter whenever the converted digit was invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      res_q   <= '0;
      mask_q  <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            src_q  <= bus.in_data;
            mode_q <= bus.mode;
            res_q  <= '0;
            mask_q <= '0;
            idx_q  <= '0;
          end
        end
        CONV: begin
          res_q[4*int'(idx_q) +: 4] <= conv_digit;
          mask_q[idx_q]             <= cur_bad;
          if (cur_bad && (err_q != {ERR_W{1'b1}})) err_q <= err_q + ERR_W'(1);
          if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.out_data     = res_q;
  assign bus.out_err_mask = mask_q;
  assign bus.err_cnt      = err_q;

endmodule
